wr_ctrl_128bit: RTL
===================

WR_CTRL_128BIT -- requirements
Module: wr_ctrl_128bit

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h00200000, byte address of frame buffer base.
REQ-002 SHALL have parameter BURST_NUM, default 600, bursts per frame (640x480); 1800 for 1280x720.
REQ-003 SHALL have parameter ADDR_INC, default 1024, byte address step per burst (64 beats x 16 B).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rst_n input 1.
REQ-005 SHALL have ports:
- ddr_init_done  input  1  DDR calibration complete.
- axi_awaddr  output  32  burst byte address.
- axi_awlen  output  8  constant 8'd63.
- axi_awsize/axi_awburst  output  3/2  constants 3'b100 / 2'd1.
- axi_awlock/axi_awpoison/axi_awurgent  output  1 each  constant 0.
- axi_awvalid  output  1  address valid.
- axi_awready  input  1  address accepted.
- axi_wdata  output  128  equals fifo_dout.
- axi_wstrb  output  16  constant all ones.
- axi_wvalid  output  1  data valid.
- axi_wlast  output  1  last beat of burst.
- axi_wready  input  1  data accepted.
- axi_bvalid  input  1  response valid.
- axi_bresp  input  2  response code.
- axi_bready  output  1  response accept.
- fifo_dout  input  128  first-word-fall-through FIFO head.
- fifo_empty  input  1  FIFO empty.
- fifo_rd_count  input  11  words held in FIFO.
- fifo_rd_en  output  1  pop FIFO head.
- frame_done  output  1  one-cycle pulse at frame end.
- wr_err  output  1  sticky error flag.

Function
REQ-006 SHALL latch ddr_init_done into a sticky init_start flag; later deassertion is ignored.
REQ-007 SHALL implement states IDLE, WAIT_DATA, WR_ADDR, WR_DATA, WR_RESP.
REQ-008 Transitions:
- IDLE->WAIT_DATA when init_start=1.
- WAIT_DATA->WR_ADDR when fifo_rd_count>=64 (63 stays).
- WR_ADDR->WR_DATA on awvalid&awready.
- WR_DATA->WR_RESP on accepted beat with wlast=1.
- WR_RESP->WAIT_DATA on bvalid&bready.
REQ-009 axi_awvalid SHALL be 1 throughout WR_ADDR and held stable with axi_awaddr until awready; no data beat before address acceptance.
REQ-010 axi_wvalid SHALL equal (state==WR_DATA)&&!fifo_empty; fifo_rd_en SHALL equal axi_wvalid&&axi_wready.
REQ-011 SHALL use a 6-bit beat counter, cleared on entry to WR_DATA and incremented per accepted beat; axi_wlast SHALL be 1 iff counter==63 and state==WR_DATA.
REQ-012 wvalid low (fifo_empty) or wready low SHALL stall the counter and FIFO with no beat lost or duplicated.
REQ-013 axi_bready SHALL be 1 only in WR_RESP.
REQ-014 On response accept, awaddr SHALL advance by ADDR_INC; if the finished burst was burst BURST_NUM-1, awaddr SHALL wrap to START_ADDR and frame_done SHALL pulse 1 cycle.
REQ-015 wr_err SHALL set when bvalid&bready with bresp!=2'b00 and clear only on reset; the burst still counts as complete.

Reset
REQ-016 On rst_n=0, at any time including mid-burst: state=IDLE, axi_awaddr=START_ADDR, axi_awvalid=axi_wvalid=axi_wlast=axi_bready=fifo_rd_en=frame_done=wr_err=0, beat counter=0, init_start=0; constant outputs unaffected.

Verification
REQ-017 ddr_init_done=1, fifo_rd_count=63 for 100 cycles -> awvalid stays 0; count->64 -> awvalid=1, awaddr=32'h00200000.
REQ-018 awready delayed 5 cycles -> awvalid/awaddr stable; then 64 beats with wlast only on beat 64, fifo_rd_en pulses exactly 64 times, bready=1 until bvalid.
REQ-019 wready toggled randomly, fifo_empty asserted 3 cycles mid-burst -> wdata sequence matches FIFO order, exactly 64 beats.
REQ-020 BURST_NUM=4, full FIFO -> awaddr 0x200000, 0x200400, 0x200800, 0x200C00, then 0x200000 with one frame_done pulse after 4th response.
REQ-021 bresp=2'b10 on burst 2 -> wr_err=1 sticky, awaddr still advances; rst_n low at beat 30 of a burst -> all outputs at reset values asynchronously, restart from IDLE at START_ADDR after ddr_init_done.

Source files
------------

// File: rtl/wr_ctrl_128bit.sv
// Frame writer: moves 64-beat x 128-bit bursts from a FWFT FIFO into DDR over an
// AXI write channel, walking a frame buffer of BURST_NUM bursts and wrapping at frame end.
module wr_ctrl_128bit #(
  parameter logic [31:0] START_ADDR = 32'h00200000,
  parameter int          BURST_NUM  = 600,
  parameter int          ADDR_INC   = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ddr_init_done,
  output logic [31:0]  axi_awaddr,
  output logic [7:0]   axi_awlen,
  output logic [2:0]   axi_awsize,
  output logic [1:0]   axi_awburst,
  output logic         axi_awlock,
  output logic         axi_awpoison,
  output logic         axi_awurgent,
  output logic         axi_awvalid,
  input  logic         axi_awready,
  output logic [127:0] axi_wdata,
  output logic [15:0]  axi_wstrb,
  output logic         axi_wvalid,
  output logic         axi_wlast,
  input  logic         axi_wready,
  input  logic         axi_bvalid,
  input  logic [1:0]   axi_bresp,
  output logic         axi_bready,
  input  logic [127:0] fifo_dout,
  input  logic         fifo_empty,
  input  logic [10:0]  fifo_rd_count,
  output logic         fifo_rd_en,
  output logic         frame_done,
  output logic         wr_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_t;

  localparam int              BCW        = (BURST_NUM > 1) ? $clog2(BURST_NUM) : 1;
  localparam logic [BCW-1:0]  LAST_BURST = BCW'(BURST_NUM - 1);
  localparam logic [31:0]     ADDR_STEP  = 32'(ADDR_INC);
  localparam logic [10:0]     BURST_LEN  = 11'd64;

  state_t          state_q, state_d;
  logic            init_start_q, init_start_d;
  logic [31:0]     awaddr_q, awaddr_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [5:0]      beat_cnt_q, beat_cnt_d;
  logic            wr_err_q, wr_err_d;
  logic            frame_done_q, frame_done_d;

  logic aw_hs, w_hs, b_hs;

  assign axi_awlen    = 8'd63;
  assign axi_awsize   = 3'b100;
  assign axi_awburst  = 2'd1;
  assign axi_awlock   = 1'b0;
  assign axi_awpoison = 1'b0;
  assign axi_awurgent = 1'b0;
  assign axi_wstrb    = 16'hFFFF;
  assign axi_wdata    = fifo_dout;

  // Handshake outputs decode straight from state so reset clears them immediately.
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = (state_q == WR_ADDR);
  assign axi_wvalid  = (state_q == WR_DATA) && !fifo_empty;
  assign axi_wlast   = (state_q == WR_DATA) && (beat_cnt_q == 6'd63);
  assign axi_bready  = (state_q == WR_RESP);
  assign fifo_rd_en  = w_hs;
  assign frame_done  = frame_done_q;
  assign wr_err      = wr_err_q;

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign b_hs  = axi_bvalid && axi_bready;

  always_comb begin
    state_d      = state_q;
    init_start_d = init_start_q | ddr_init_done;
    awaddr_d     = awaddr_q;
    burst_cnt_d  = burst_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    wr_err_d     = wr_err_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_start_q) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (fifo_rd_count >= BURST_LEN) state_d = WR_ADDR;
      end
      WR_ADDR: begin
        if (aw_hs) begin
          state_d    = WR_DATA;
          beat_cnt_d = 6'd0;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 6'd1;
          if (axi_wlast) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        // An error response still retires the burst; only the sticky flag records it.
        if (b_hs) begin
          state_d = WAIT_DATA;
          if (axi_bresp != 2'b00) wr_err_d = 1'b1;
          if (burst_cnt_q == LAST_BURST) begin
            burst_cnt_d  = '0;
            awaddr_d     = START_ADDR;
            frame_done_d = 1'b1;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
            awaddr_d    = awaddr_q + ADDR_STEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      init_start_q <= 1'b0;
      awaddr_q     <= START_ADDR;
      burst_cnt_q  <= '0;
      beat_cnt_q   <= 6'd0;
      wr_err_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_start_q <= init_start_d;
      awaddr_q     <= awaddr_d;
      burst_cnt_q  <= burst_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_err_q     <= wr_err_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
